// File: rtl/memory_arbiter_pkg.sv
// Shared state encoding and port constants for memory_arbiter.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    function automatic logic [1:0] port_onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/memory_arbiter_pick.sv
// Winner selection for memory_arbiter; MEMORY_ARBITER_FIXED_PRIORITY_EN
// selects data-port priority instead of round-robin.
module arbiter_pick (
    input  logic [1:0] m_req,
    input  logic       last,
    output logic       winner,
    output logic       any_req
);
    import memory_arbiter_pkg::*;

    assign any_req = |m_req;

`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
    always_comb begin
        winner = m_req[PORT_DATA] ? PORT_DATA : PORT_FETCH;
    end
`else
    // On a tie the port that did not win last time goes first.
    always_comb begin
        if (&m_req)
            winner = ~last;
        else if (m_req[PORT_DATA])
            winner = PORT_DATA;
        else
            winner = PORT_FETCH;
    end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port, 1-cycle-latency memory between fetch and load/store.
// Build option: MEMORY_ARBITER_FIXED_PRIORITY_EN (data port wins contention).
module memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              m_req,
    input  logic [1:0]              m_we,
    input  logic [2*ADDR_WIDTH-1:0] m_addr,
    input  logic [2*DATA_WIDTH-1:0] m_wdata,
    output logic [1:0]              m_gnt,
    output logic [1:0]              m_rvalid,
    output logic [DATA_WIDTH-1:0]   m_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);
    import memory_arbiter_pkg::*;

    state_t                r_state;
    logic                  r_last;
    logic                  r_port;
    logic [1:0]            r_gnt;
    logic [1:0]            r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic                  w_winner;
    logic                  w_any;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    arbiter_pick u_pick (
        .m_req   (m_req),
        .last    (r_last),
        .winner  (w_winner),
        .any_req (w_any)
    );

    assign w_addr  = w_winner ? m_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                              : m_addr[ADDR_WIDTH-1:0];
    assign w_wdata = w_winner ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                              : m_wdata[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_last      <= PORT_DATA;
            r_port      <= PORT_FETCH;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_rdata     <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_mem_en <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt       <= port_onehot(w_winner);
                        r_port      <= w_winner;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= m_we[w_winner];
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_wdata;
`ifndef MEMORY_ARBITER_FIXED_PRIORITY_EN
                        r_last      <= w_winner;
`endif
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_mem_we) begin
                        r_state <= IDLE;
                    end else begin
                        r_rvalid <= port_onehot(r_port);
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    r_rdata <= mem_rdata;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory data arrives during RESP, so it bypasses the hold register then.
    assign m_rdata   = (r_state == RESP) ? mem_rdata : r_rdata;
    assign m_gnt     = r_gnt;
    assign m_rvalid  = r_rvalid;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter with a timestamp-based reference model.
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m_req;
    logic [1:0]  m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_gnt;
    logic [1:0]  m_rvalid;
    logic [31:0] m_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          free_at = 0;
    int          gnt_at = -1;
    int          rv_at = -1;
    logic        gnt_port = 1'b0;
    logic        last = 1'b1;
    logic [31:0] rv_data = '0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic [31:0] exp_rdata = '0;

    memory_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_gnt     (m_gnt),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    function automatic logic [1:0] oh(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        m_req[p]         = 1'b1;
        m_we[p]          = we;
        m_addr[p*32+:32]  = a;
        m_wdata[p*32+:32] = d;
    endtask

    // One clock: model reacts to the inputs seen at the edge, then checks.
    task automatic tick();
        logic w;
        @(posedge clk);
        cyc++;
        if (!reset) begin
            free_at   = cyc + 1;
            last      = 1'b1;
            gnt_at    = -1;
            rv_at     = -1;
            exp_we    = 1'b0;
            exp_addr  = '0;
            exp_wdata = '0;
            exp_rdata = '0;
        end else if (cyc >= free_at && m_req != 2'b00) begin
`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
            w = m_req[1];
`else
            w = (m_req == 2'b11) ? ~last : m_req[1];
`endif
            last      = w;
            gnt_at    = cyc;
            gnt_port  = w;
            exp_we    = m_we[w];
            exp_addr  = m_addr[w*32+:32];
            exp_wdata = m_wdata[w*32+:32];
            if (exp_we) begin
                ref_mem[exp_addr[9:2]] = exp_wdata;
                free_at = cyc + 2;
            end else begin
                rv_at   = cyc + 1;
                rv_data = ref_mem[exp_addr[9:2]];
                free_at = cyc + 3;
            end
        end
        if (cyc == rv_at) exp_rdata = rv_data;
        @(negedge clk);
        chk("m_gnt", m_gnt, (cyc == gnt_at) ? oh(gnt_port) : 2'b00);
        chk("mem_en", mem_en, cyc == gnt_at);
        chk("mem_we", mem_we, exp_we);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
        chk("m_rvalid", m_rvalid, (cyc == rv_at) ? oh(gnt_port) : 2'b00);
        chk("m_rdata", m_rdata, exp_rdata);
        if (cyc == gnt_at) m_req[gnt_port] = 1'b0;
    endtask

    task automatic rand_req(input int p);
        set_req(p, 1'($urandom_range(0, 1)),
                {22'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            ram[i]     = ref_mem[i];
        end
        ref_mem[4] = 32'hDEADBEEF;
        ram[4]     = 32'hDEADBEEF;
        reset   = 1'b0;
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Port 0 read of a known word.
        set_req(0, 1'b0, 32'h10, 32'h0);
        repeat (4) tick();
        chk("rd_deadbeef", m_rdata, 32'hDEADBEEF);

        // Port 1 write, then port 0 reads it back.
        set_req(1, 1'b1, 32'h20, 32'h12345678);
        repeat (3) tick();
        set_req(0, 1'b0, 32'h20, 32'h0);
        repeat (4) tick();
        chk("readback", m_rdata, 32'h12345678);

        // Both ports reading continuously.
        for (int k = 0; k < 16; k++) begin
            if (!m_req[0]) set_req(0, 1'b0, 32'h10, 32'h0);
            if (!m_req[1]) set_req(1, 1'b0, 32'h20, 32'h0);
            tick();
        end
        m_req = '0;
        repeat (4) tick();

        // Request withdrawn while the arbiter is busy: never granted.
        set_req(0, 1'b0, 32'h30, 32'h0);
        tick();
        set_req(1, 1'b0, 32'h34, 32'h0);
        tick();
        m_req[1] = 1'b0;
        repeat (4) tick();

        // Port 1 arrives while port 0 is in ACCESS.
        set_req(0, 1'b0, 32'h40, 32'h0);
        tick();
        set_req(1, 1'b1, 32'h44, 32'hCAFEF00D);
        repeat (5) tick();

        // Reset aborts an in-flight read; the next tie goes to port 0.
        set_req(0, 1'b0, 32'h10, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_req(0, 1'b0, 32'h20, 32'h0);
        set_req(1, 1'b0, 32'h10, 32'h0);
        repeat (8) tick();

        // Reset landing in RESP.
        set_req(1, 1'b0, 32'h44, 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Random traffic with occasional withdrawals.
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!m_req[p] && $urandom_range(0, 1) == 0)
                    rand_req(p);
                else if (m_req[p] && $urandom_range(0, 15) == 0)
                    m_req[p] = 1'b0;
            end
            reset = (k == 200) ? 1'b0 : 1'b1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester arbiter that shares one single-port, one-cycle-read-latency memory between instruction fetch (port 0) and load/store (port 1) of the core. It accepts one access at a time, grants by round-robin on contention, drives the memory port from registers and returns read data with a per-port valid pulse. It sits between the core and the unified memory, replacing separate instruction and data memories once the core stalls on fetch/data handshakes.

## Interface
- ADDR_WIDTH, 32, width of requester and memory addresses
- DATA_WIDTH, 32, width of write/read data
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- m_req  in  2  per-port request; bit i = port i
- m_we  in  2  per-port write enable (1 = write, 0 = read)
- m_addr  in  2*ADDR_WIDTH  per-port address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wdata  in  2*DATA_WIDTH  per-port write data, same packing
- m_gnt  out  2  one-cycle pulse: port i's request accepted
- m_rvalid  out  2  one-cycle pulse: m_rdata valid for port i
- m_rdata  out  DATA_WIDTH  read data, shared by both ports
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en with mem_we=0

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: no m_req -> stay. Any m_req -> pick winner, register its we/addr/wdata onto mem_*, set mem_en=1, m_gnt[winner]=1, go ACCESS.
- ACCESS (1 cycle): mem_en, m_gnt pulse visible; write -> IDLE; read -> RESP.
- RESP (1 cycle): m_rvalid[winner]=1, m_rdata=mem_rdata; -> IDLE.
- Winner: single requester wins; both requesting -> port != last; last updated to winner on every grant; last resets to 1 (port 0 wins first tie).
- Requester holds m_req, m_we, m_addr, m_wdata stable until it sees m_gnt; may change or drop them the cycle after m_gnt. Requests arriving outside IDLE are not sampled until next IDLE.
- Dropping m_req before m_gnt withdraws the request; no grant is issued.
- m_rdata holds last read value between pulses; mem_addr/mem_wdata/mem_we hold last values, only mem_en qualifies them.

## Timing
- Reset (reset=0 at an edge): state IDLE, last=1, m_gnt=0, m_rvalid=0, m_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. Reset mid-ACCESS/RESP aborts; no m_rvalid for the in-flight read.
- Request in IDLE at cycle N: m_gnt and mem_en high in N+1; read data pulse m_rvalid in N+2.
- Throughput: read every 3 cycles, write every 2 cycles; back-to-back contention alternates ports.
- m_gnt and m_rvalid are one-hot or zero; never both bits set.

## Configuration
- MEMORY_ARBITER_FIXED_PRIORITY_EN defined: port 1 (data) always wins contention; last pointer unused. Undefined: round-robin as above.

## Structure
- Package memory_arbiter_pkg: state enum (IDLE, ACCESS, RESP), port index constants PORT_FETCH=0, PORT_DATA=1.
- One combinational sub-module arbiter_pick: inputs m_req, last; output winner index and any_req; holds the macro-selected policy.

## Test plan
- Port 0 read addr 0x10, mem holds 0xDEADBEEF -> m_gnt=01 at N+1, mem_en=1 mem_addr=0x10, m_rvalid=01 m_rdata=0xDEADBEEF at N+2.
- Port 1 write addr 0x20 data 0x12345678 -> m_gnt=10 at N+1, mem_we=1, no m_rvalid, readback via port 0 returns 0x12345678.
- Both ports request reads continuously from reset -> grants alternate 01,10,01,10; fixed-priority build -> always 10.
- Request port 0, drop m_req before IDLE sees it (held 0 in IDLE) -> no m_gnt, mem_en stays 0.
- Assert reset=0 during RESP of a read -> next cycle all outputs 0, no m_rvalid; next request granted to port 0 on tie.
- Port 1 request raised while port 0 in ACCESS -> port 1 granted on the first IDLE cycle after port 0 completes.
